// File: rtl/custom_pkg.sv
// RV32 major opcodes used to classify retired instructions.
package custom_pkg;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
endpackage

// File: rtl/trace_pkg.sv
// Trace record type, frame FSM states and header layout for riscv_commit_tracer.
package trace_pkg;
    localparam int XLEN = 32;

    localparam int HDR_SEQ_LSB   = 24;
    localparam int HDR_RD_LSB    = 19;
    localparam int HDR_FLAGS_LSB = 16;
    localparam int HDR_DROP_LSB  = 8;
    localparam logic [7:0] HDR_SYNC = 8'hA5;

    localparam int FL_RD = 2;
    localparam int FL_MA = 1;
    localparam int FL_MD = 0;

    typedef enum logic [2:0] {
        ST_IDLE, ST_HDR, ST_PC, ST_INSTR, ST_RDATA, ST_MADDR, ST_MDATA
    } trace_state_e;

    typedef struct packed {
        logic [7:0]      seq;
        logic [4:0]      rd;
        logic [2:0]      flags;
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [XLEN-1:0] rdata;
        logic [XLEN-1:0] maddr;
        logic [XLEN-1:0] mdata;
    } trace_rec_t;

    // Word that follows st in a frame; ST_IDLE means st is the last word.
    function automatic trace_state_e next_word(input trace_state_e st, input logic [2:0] flags);
        trace_state_e nxt;
        nxt = ST_IDLE;
        case (st)
            ST_HDR:   nxt = ST_PC;
            ST_PC:    nxt = ST_INSTR;
            ST_INSTR: nxt = flags[FL_RD] ? ST_RDATA : (flags[FL_MA] ? ST_MADDR : ST_IDLE);
            ST_RDATA: nxt = flags[FL_MA] ? ST_MADDR : ST_IDLE;
            ST_MADDR: nxt = flags[FL_MD] ? ST_MDATA : ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

    function automatic logic [31:0] hdr_word(input trace_rec_t r, input logic [7:0] drops);
        return (32'(r.seq) << HDR_SEQ_LSB) | (32'(r.rd) << HDR_RD_LSB)
             | (32'(r.flags) << HDR_FLAGS_LSB) | (32'(drops) << HDR_DROP_LSB)
             | 32'(HDR_SYNC);
    endfunction

    function automatic logic [31:0] frame_word(input trace_state_e st, input trace_rec_t r,
                                               input logic [7:0] drops);
        logic [31:0] w;
        w = '0;
        case (st)
            ST_HDR:   w = hdr_word(r, drops);
            ST_PC:    w = r.pc;
            ST_INSTR: w = r.instr;
            ST_RDATA: w = r.rdata;
            ST_MADDR: w = r.maddr;
            ST_MDATA: w = r.mdata;
            default:  w = '0;
        endcase
        return w;
    endfunction
endpackage

// File: rtl/riscv_trace_fifo.sv
// Synchronous FIFO of trace records; exposes the head and the entry behind it so
// the framer can start the next header on the same edge that pops the current one.
module riscv_trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     push_i,
    input  trace_rec_t               push_rec_i,
    input  logic                     pop_i,
    output trace_rec_t               head_o,
    output trace_rec_t               next_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    trace_rec_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_i);
        rd_ptr_d = rd_ptr_q + AW'(pop_i);
        count_d  = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // When full, wr_ptr equals rd_ptr: a same-edge push overwrites the slot being popped.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem[wr_ptr_q] <= push_rec_i;
        end
    end

    assign head_o  = mem[rd_ptr_q];
    assign next_o  = mem[rd_ptr_q + AW'(1)];
    assign count_o = count_q;
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
endmodule

// File: rtl/riscv_commit_tracer.sv
// Buffers retired-instruction records and streams them as 3..5 word frames.
// Build option RISCV_TRACE_DROPCNT_EN adds a per-header dropped-record count.
module riscv_commit_tracer
    import custom_pkg::*;
    import trace_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            commit_valid_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     instr_i,
    input  logic [4:0]      rd_addr_i,
    input  logic [XLEN-1:0] rd_data_i,
    input  logic [XLEN-1:0] mem_addr_i,
    input  logic [XLEN-1:0] mem_data_i,
    output logic            tvalid_o,
    output logic [31:0]     tdata_o,
    output logic            tlast_o,
    input  logic            tready_i,
    output logic            overflow_o
);
    localparam int CW = $clog2(DEPTH) + 1;

    trace_state_e  state_q, state_d;
    logic          tvalid_q, tvalid_d;
    logic [31:0]   tdata_q, tdata_d;
    logic          tlast_q, tlast_d;
    logic [7:0]    seq_q, seq_d;
    logic          overflow_q, overflow_d;

    trace_rec_t    push_rec, head, next_rec_fifo, next_rec;
    logic [CW-1:0] count;
    logic          full, empty;
    logic          is_load, is_store, is_branch;
    logic          hs, pop, push_en, drop, more, hdr_load;
    logic [7:0]    hdr_drops;
    trace_state_e  word_nxt;

    assign is_load   = (instr_i[6:0] == OPC_LOAD);
    assign is_store  = (instr_i[6:0] == OPC_STORE);
    assign is_branch = (instr_i[6:0] == OPC_BRANCH);

    always_comb begin
        push_rec       = '0;
        push_rec.seq   = seq_q;
        push_rec.rd    = rd_addr_i;
        push_rec.flags = {(rd_addr_i != 5'd0) && !is_store && !is_branch,
                          is_load || is_store, is_store};
        push_rec.pc    = pc_i;
        push_rec.instr = instr_i;
        push_rec.rdata = rd_data_i;
        push_rec.maddr = mem_addr_i;
        push_rec.mdata = mem_data_i;
    end

    assign hs       = tvalid_q && tready_i;
    assign word_nxt = next_word(state_q, head.flags);
    assign pop      = hs && (word_nxt == ST_IDLE);
    assign push_en  = commit_valid_i && (!full || pop);
    assign drop     = commit_valid_i && !push_en;
    // With a single entry left, a record pushed on the popping edge is not yet readable.
    assign next_rec = (count > CW'(1)) ? next_rec_fifo : push_rec;
    assign more     = (count > CW'(1)) || push_en;

    riscv_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .push_i     (push_en),
        .push_rec_i (push_rec),
        .pop_i      (pop),
        .head_o     (head),
        .next_o     (next_rec_fifo),
        .count_o    (count),
        .full_o     (full),
        .empty_o    (empty)
    );

    always_comb begin
        state_d    = state_q;
        tvalid_d   = tvalid_q;
        tdata_d    = tdata_q;
        tlast_d    = tlast_q;
        hdr_load   = 1'b0;
        seq_d      = commit_valid_i ? seq_q + 8'd1 : seq_q;
        overflow_d = overflow_q | drop;
        if (state_q == ST_IDLE) begin
            if (!empty) begin
                state_d  = ST_HDR;
                tvalid_d = 1'b1;
                tdata_d  = hdr_word(head, hdr_drops);
                tlast_d  = 1'b0;
                hdr_load = 1'b1;
            end
        end else if (hs) begin
            if (word_nxt == ST_IDLE) begin
                if (more) begin
                    state_d  = ST_HDR;
                    tdata_d  = hdr_word(next_rec, hdr_drops);
                    tlast_d  = 1'b0;
                    hdr_load = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                    tvalid_d = 1'b0;
                    tdata_d  = '0;
                    tlast_d  = 1'b0;
                end
            end else begin
                state_d = word_nxt;
                tdata_d = frame_word(word_nxt, head, 8'd0);
                tlast_d = (next_word(word_nxt, head.flags) == ST_IDLE);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ST_IDLE;
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
            tlast_q    <= 1'b0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
            tlast_q    <= tlast_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef RISCV_TRACE_DROPCNT_EN
    logic [7:0] dropcnt_q, dropcnt_d;

    // Captured when a header word is loaded so the word stays stable while stalled.
    always_comb begin
        if (hdr_load) begin
            dropcnt_d = {7'd0, drop};
        end else if (drop && (dropcnt_q != 8'hFF)) begin
            dropcnt_d = dropcnt_q + 8'd1;
        end else begin
            dropcnt_d = dropcnt_q;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            dropcnt_q <= '0;
        end else begin
            dropcnt_q <= dropcnt_d;
        end
    end

    assign hdr_drops = dropcnt_q;
`else
    assign hdr_drops = 8'd0;
`endif

    assign tvalid_o   = tvalid_q;
    assign tdata_o    = tdata_q;
    assign tlast_o    = tlast_q;
    assign overflow_o = overflow_q;
endmodule

// File: tb/tb_riscv_commit_tracer.sv
// Directed bench for riscv_commit_tracer: frame layout, latency, overflow, stalls, reset.
module tb_riscv_commit_tracer;
    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        commit_valid_i;
    logic [31:0] pc_i, instr_i, rd_data_i, mem_addr_i, mem_data_i;
    logic [4:0]  rd_addr_i;
    logic        tvalid_o, tlast_o, tready_i, overflow_o;
    logic [31:0] tdata_o;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];

`ifdef RISCV_TRACE_DROPCNT_EN
    localparam logic [7:0] DC_AFTER_DROPS = 8'd4;
`else
    localparam logic [7:0] DC_AFTER_DROPS = 8'd0;
`endif

    always #5 clk_i = ~clk_i;

    riscv_commit_tracer #(.XLEN(32), .DEPTH(8)) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .commit_valid_i (commit_valid_i),
        .pc_i           (pc_i),
        .instr_i        (instr_i),
        .rd_addr_i      (rd_addr_i),
        .rd_data_i      (rd_data_i),
        .mem_addr_i     (mem_addr_i),
        .mem_data_i     (mem_data_i),
        .tvalid_o       (tvalid_o),
        .tdata_o        (tdata_o),
        .tlast_o        (tlast_o),
        .tready_i       (tready_i),
        .overflow_o     (overflow_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Expected frame built from the record fields and the classification rules.
    task automatic expect_frame(input logic [7:0] seq, input logic [4:0] rd, input logic [31:0] pc,
                                input logic [31:0] instr, input logic [31:0] rdata,
                                input logic [31:0] maddr, input logic [31:0] mdata,
                                input logic [7:0] dc);
        logic [6:0] op;
        logic ld, st, br, hr;
        op = instr[6:0];
        ld = (op == 7'b0000011);
        st = (op == 7'b0100011);
        br = (op == 7'b1100011);
        hr = (rd != 5'd0) && !st && !br;
        exp_q.push_back({seq, rd, hr, ld | st, st, dc, 8'hA5});
        exp_q.push_back(pc);
        exp_q.push_back(instr);
        if (hr) exp_q.push_back(rdata);
        if (ld | st) exp_q.push_back(maddr);
        if (st) exp_q.push_back(mdata);
    endtask

    task automatic set_rec(input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] instr,
                           input logic [31:0] rdata, input logic [31:0] maddr, input logic [31:0] mdata);
        rd_addr_i = rd; pc_i = pc; instr_i = instr;
        rd_data_i = rdata; mem_addr_i = maddr; mem_data_i = mdata;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] instr,
                          input logic [31:0] rdata, input logic [31:0] maddr, input logic [31:0] mdata);
        set_rec(rd, pc, instr, rdata, maddr, mdata);
        commit_valid_i = 1'b1;
        @(posedge clk_i); #1;
        commit_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        commit_valid_i = 1'b0;
        tready_i = 1'b0;
        @(posedge clk_i); @(posedge clk_i); #1;
        rstn_i = 1'b1;
    endtask

    // Receives the frame at the head of exp_q. rnd toggles tready randomly and checks
    // that stalled words hold; nobubble requires the header to be present immediately;
    // push_on_last commits the preset record on the edge of the final-word handshake.
    task automatic recv_frame(input string tag, input bit rnd, input bit nobubble, input bit push_on_last);
        int n, waited;
        bit got;
        logic [31:0] hdr, held_d, exp;
        logic held_l;
        if (exp_q.size() == 0) begin
            check({tag, "_noexp"}, 32'd0, 32'd1);
            return;
        end
        hdr = exp_q[0];
        n = 3 + int'(hdr[18]) + int'(hdr[17]) + int'(hdr[16]);
        for (int i = 0; i < n; i++) begin
            waited = 0;
            got = 1'b0;
            while (!got) begin
                tready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (tvalid_o && tready_i) begin
                    got = 1'b1;
                end else if (waited > 200) begin
                    check($sformatf("%s_timeout_w%0d", tag, i), 32'd0, 32'd1);
                    tready_i = 1'b0;
                    return;
                end else begin
                    held_d = tdata_o;
                    held_l = tlast_o;
                    @(posedge clk_i); #1;
                    if (held_d !== 32'd0 || held_l) begin
                        check($sformatf("%s_stall_valid_w%0d", tag, i), 32'(tvalid_o), 32'd1);
                        check($sformatf("%s_stall_data_w%0d", tag, i), tdata_o, held_d);
                        check($sformatf("%s_stall_last_w%0d", tag, i), 32'(tlast_o), 32'(held_l));
                    end
                    waited++;
                end
            end
            if (nobubble && i == 0) check({tag, "_bubble"}, 32'(waited), 32'd0);
            exp = exp_q.pop_front();
            check($sformatf("%s_w%0d", tag, i), tdata_o, exp);
            check($sformatf("%s_last_w%0d", tag, i), 32'(tlast_o), 32'(i == n - 1));
            if (push_on_last && i == n - 1) commit_valid_i = 1'b1;
            @(posedge clk_i); #1;
            commit_valid_i = 1'b0;
        end
        $display("frame %s hdr=0x%08h words=%0d", tag, hdr, n);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_rec(5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        do_reset();
        check("rst_tvalid", 32'(tvalid_o), 32'd0);
        check("rst_tdata", tdata_o, 32'd0);
        check("rst_tlast", 32'(tlast_o), 32'd0);
        check("rst_overflow", 32'(overflow_o), 32'd0);

        // ADD x5: latency and hand-computed header
        tready_i = 1'b1;
        commit(5'd5, 32'h8000_0000, 32'h0020_82B3, 32'h0000_002A, 32'h0, 32'h0);
        check("add_lat_edge0", 32'(tvalid_o), 32'd0);
        @(posedge clk_i); #1;
        check("add_lat_edge1", 32'(tvalid_o), 32'd1);
        check("add_hdr_const", tdata_o, 32'h002C_00A5);
        expect_frame(8'd0, 5'd5, 32'h8000_0000, 32'h0020_82B3, 32'h0000_002A, 32'h0, 32'h0, 8'd0);
        recv_frame("add", 1'b0, 1'b0, 1'b0);
        check("idle_after_add", 32'(tvalid_o), 32'd0);

        commit(5'd0, 32'h8000_0010, 32'h00A1_2023, 32'h1111_1111, 32'h0000_2000, 32'hDEAD_BEEF);
        @(posedge clk_i); #1;
        check("sw_hdr_const", tdata_o, 32'h0103_00A5);
        expect_frame(8'd1, 5'd0, 32'h8000_0010, 32'h00A1_2023, 32'h1111_1111, 32'h0000_2000, 32'hDEAD_BEEF, 8'd0);
        recv_frame("sw", 1'b0, 1'b0, 1'b0);

        commit(5'd8, 32'h8000_0014, 32'h0020_8463, 32'h0000_1234, 32'h0000_5555, 32'h0000_6666);
        @(posedge clk_i); #1;
        check("beq_hdr_const", tdata_o, 32'h0240_00A5);
        expect_frame(8'd2, 5'd8, 32'h8000_0014, 32'h0020_8463, 32'h0000_1234, 32'h0000_5555, 32'h0000_6666, 8'd0);
        recv_frame("beq", 1'b0, 1'b0, 1'b0);

        commit(5'd0, 32'h8000_0018, 32'h0000_0013, 32'h0000_0099, 32'h0, 32'h0);
        @(posedge clk_i); #1;
        check("addi_x0_hdr_const", tdata_o, 32'h0300_00A5);
        expect_frame(8'd3, 5'd0, 32'h8000_0018, 32'h0000_0013, 32'h0000_0099, 32'h0, 32'h0, 8'd0);
        recv_frame("addi_x0", 1'b0, 1'b0, 1'b0);

        commit(5'd6, 32'h8000_001C, 32'h0001_2303, 32'hCAFE_F00D, 32'h0000_3000, 32'h0000_7777);
        @(posedge clk_i); #1;
        check("lw_hdr_const", tdata_o, 32'h0436_00A5);
        expect_frame(8'd4, 5'd6, 32'h8000_001C, 32'h0001_2303, 32'hCAFE_F00D, 32'h0000_3000, 32'h0000_7777, 8'd0);
        recv_frame("lw", 1'b0, 1'b0, 1'b0);

        // back-to-back frames with no idle cycle between them
        commit(5'd1, 32'h8000_0020, 32'h0020_80B3, 32'h0000_0005, 32'h0, 32'h0);
        commit(5'd0, 32'h8000_0024, 32'h0000_0013, 32'h0, 32'h0, 32'h0);
        expect_frame(8'd5, 5'd1, 32'h8000_0020, 32'h0020_80B3, 32'h0000_0005, 32'h0, 32'h0, 8'd0);
        expect_frame(8'd6, 5'd0, 32'h8000_0024, 32'h0000_0013, 32'h0, 32'h0, 32'h0, 8'd0);
        recv_frame("b2b_a", 1'b0, 1'b0, 1'b0);
        recv_frame("b2b_b", 1'b0, 1'b1, 1'b0);

        // 12 commits into a stalled sink: 8 kept, 4 dropped
        do_reset();
        for (int i = 0; i < 12; i++) begin
            commit(5'(i + 1), 32'h0000_1000 + 32'(4 * i), 32'h0020_82B3, 32'h0000_0100 + 32'(i), 32'h0, 32'h0);
            if (i < 8)
                expect_frame(8'(i), 5'(i + 1), 32'h0000_1000 + 32'(4 * i), 32'h0020_82B3,
                             32'h0000_0100 + 32'(i), 32'h0, 32'h0, (i == 1) ? DC_AFTER_DROPS : 8'd0);
            if (i == 7) check("ovf_not_yet", 32'(overflow_o), 32'd0);
        end
        check("ovf_set", 32'(overflow_o), 32'd1);
        repeat (8) begin @(posedge clk_i); #1; end
        check("ovf_stall_valid", 32'(tvalid_o), 32'd1);
        check("ovf_stall_hdr", tdata_o, 32'h000C_00A5);
        for (int f = 0; f < 8; f++) recv_frame($sformatf("ovf_f%0d", f), 1'b0, 1'b1, 1'b0);
        commit(5'd3, 32'h0000_2000, 32'h0020_81B3, 32'h0000_0777, 32'h0, 32'h0);
        expect_frame(8'd12, 5'd3, 32'h0000_2000, 32'h0020_81B3, 32'h0000_0777, 32'h0, 32'h0, 8'd0);
        recv_frame("ovf_seq12", 1'b0, 1'b0, 1'b0);
        check("ovf_sticky", 32'(overflow_o), 32'd1);

        // full FIFO: commit on the final-word handshake edge must not drop
        do_reset();
        for (int i = 0; i < 8; i++) begin
            commit(5'd2, 32'h0000_3000 + 32'(4 * i), 32'h0020_8133, 32'(i), 32'h0, 32'h0);
            expect_frame(8'(i), 5'd2, 32'h0000_3000 + 32'(4 * i), 32'h0020_8133, 32'(i), 32'h0, 32'h0, 8'd0);
        end
        set_rec(5'd0, 32'h0000_3100, 32'h0000_0013, 32'h0, 32'h0, 32'h0);
        expect_frame(8'd8, 5'd0, 32'h0000_3100, 32'h0000_0013, 32'h0, 32'h0, 32'h0, 8'd0);
        recv_frame("full_f0", 1'b0, 1'b0, 1'b1);
        check("full_pushpop_nodrop", 32'(overflow_o), 32'd0);
        for (int f = 1; f < 9; f++) recv_frame($sformatf("full_f%0d", f), 1'b0, 1'b1, 1'b0);

        // random sink backpressure over mixed frame lengths
        do_reset();
        commit(5'd7, 32'h0000_4000, 32'h0020_83B3, 32'h0000_0A0A, 32'h0, 32'h0);
        commit(5'd0, 32'h0000_4004, 32'h00A1_2023, 32'h0, 32'h0000_4400, 32'h1234_5678);
        commit(5'd9, 32'h0000_4008, 32'h0001_2483, 32'h0BAD_0BAD, 32'h0000_4800, 32'h0);
        commit(5'd4, 32'h0000_400C, 32'h0020_8263, 32'h0, 32'h0, 32'h0);
        commit(5'd11, 32'h0000_4010, 32'h0010_0593, 32'h0000_0001, 32'h0, 32'h0);
        commit(5'd0, 32'h0000_4014, 32'h0000_0013, 32'h0, 32'h0, 32'h0);
        expect_frame(8'd0, 5'd7, 32'h0000_4000, 32'h0020_83B3, 32'h0000_0A0A, 32'h0, 32'h0, 8'd0);
        expect_frame(8'd1, 5'd0, 32'h0000_4004, 32'h00A1_2023, 32'h0, 32'h0000_4400, 32'h1234_5678, 8'd0);
        expect_frame(8'd2, 5'd9, 32'h0000_4008, 32'h0001_2483, 32'h0BAD_0BAD, 32'h0000_4800, 32'h0, 8'd0);
        expect_frame(8'd3, 5'd4, 32'h0000_400C, 32'h0020_8263, 32'h0, 32'h0, 32'h0, 8'd0);
        expect_frame(8'd4, 5'd11, 32'h0000_4010, 32'h0010_0593, 32'h0000_0001, 32'h0, 32'h0, 8'd0);
        expect_frame(8'd5, 5'd0, 32'h0000_4014, 32'h0000_0013, 32'h0, 32'h0, 32'h0, 8'd0);
        for (int f = 0; f < 6; f++) recv_frame($sformatf("rnd_f%0d", f), 1'b1, 1'b0, 1'b0);

        // reset in the middle of a frame
        tready_i = 1'b1;
        commit(5'd5, 32'h0000_5000, 32'h0020_82B3, 32'h0000_0055, 32'h0, 32'h0);
        @(posedge clk_i); #1;
        check("midrst_hdr_valid", 32'(tvalid_o), 32'd1);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        #2 rstn_i = 1'b0;
        #1;
        check("midrst_async_tvalid", 32'(tvalid_o), 32'd0);
        check("midrst_async_tdata", tdata_o, 32'd0);
        @(posedge clk_i); #1;
        check("midrst_tvalid", 32'(tvalid_o), 32'd0);
        check("midrst_tdata", tdata_o, 32'd0);
        check("midrst_tlast", 32'(tlast_o), 32'd0);
        check("midrst_overflow", 32'(overflow_o), 32'd0);
        rstn_i = 1'b1;
        commit(5'd5, 32'h0000_6000, 32'h0020_82B3, 32'h0000_0066, 32'h0, 32'h0);
        expect_frame(8'd0, 5'd5, 32'h0000_6000, 32'h0020_82B3, 32'h0000_0066, 32'h0, 32'h0, 8'd0);
        recv_frame("after_rst", 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
